// File: rtl/dlfloat_operand_loader.sv
// Pairs consecutive DLFloat16 words into (A, B) operands and queues them for the MAC.
// Optional DLFLOAT_ZERO_FLUSH_EN: zero-exponent operands are replaced by +0 at push time.
module dlfloat_operand_loader #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [15:0]              in_data,
    input  logic                     in_valid,
    input  logic                     in_clr,
    input  logic                     in_abort,
    output logic                     in_ready,
    output logic [15:0]              op_a,
    output logic [15:0]              op_b,
    output logic                     op_clr,
    output logic                     op_valid,
    input  logic                     op_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         pair_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {WAIT_A, WAIT_B} state_t;

    typedef struct packed {
        logic        clr;
        logic [15:0] a;
        logic [15:0] b;
    } entry_t;

    state_t             state_q, state_d;
    logic [15:0]        a_hold_q, a_hold_d;
    logic               clr_hold_q, clr_hold_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];

    logic   full, empty, accept, push, pop;
    entry_t head;

    function automatic logic [15:0] flush(input logic [15:0] w);
`ifdef DLFLOAT_ZERO_FLUSH_EN
        return (w[14:9] == 6'd0) ? 16'h0000 : w;
`else
        return w;
`endif
    endfunction

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    // in_ready depends only on registered state, never on op_ready
    assign in_ready = (state_q == WAIT_A) || !full;
    assign accept   = in_valid && in_ready;
    assign push     = accept && !in_abort && (state_q == WAIT_B);
    assign pop      = !empty && op_ready;

    assign head       = mem_q[rd_ptr_q];
    assign op_valid   = !empty;
    assign op_a       = empty ? '0 : head.a;
    assign op_b       = empty ? '0 : head.b;
    assign op_clr     = empty ? 1'b0 : head.clr;
    assign fifo_level = level_q;
    assign pair_cnt   = cnt_q;

    always_comb begin
        state_d    = state_q;
        a_hold_d   = a_hold_q;
        clr_hold_d = clr_hold_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        cnt_d      = cnt_q;
        mem_d      = mem_q;

        if (in_abort) begin
            state_d = WAIT_A;
        end else if (accept) begin
            if (state_q == WAIT_A) begin
                a_hold_d   = in_data;
                clr_hold_d = in_clr;
                state_d    = WAIT_B;
            end else begin
                state_d = WAIT_A;
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = '{clr: clr_hold_q, a: flush(a_hold_q), b: flush(in_data)};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d    = head.clr ? CNT_W'(1) : cnt_q + CNT_W'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_A;
            a_hold_q   <= '0;
            clr_hold_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            cnt_q      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            a_hold_q   <= a_hold_d;
            clr_hold_q <= clr_hold_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
        end
    end
endmodule

// File: tb/tb_dlfloat_operand_loader.sv
// Randomized and directed bench for dlfloat_operand_loader against a queue-based reference.
module tb_dlfloat_operand_loader;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_clr = 1'b0;
    logic        in_abort = 1'b0;
    logic        in_ready;
    logic [15:0] op_a, op_b;
    logic        op_clr, op_valid;
    logic        op_ready = 1'b0;
    logic [2:0]  fifo_level;
    logic [CNT_W-1:0] pair_cnt;

    int total = 0;
    int bad   = 0;

    dlfloat_operand_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_clr(in_clr), .in_abort(in_abort), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_clr(op_clr), .op_valid(op_valid),
        .op_ready(op_ready), .fifo_level(fifo_level), .pair_cnt(pair_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        clr;
        logic [15:0] a;
        logic [15:0] b;
    } pair_t;

    pair_t            q[$];
    bit               m_have_a = 0;
    logic [15:0]      m_a = '0;
    logic             m_clr = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;

    function automatic logic [15:0] ref_flush(input logic [15:0] w);
`ifdef DLFLOAT_ZERO_FLUSH_EN
        if (w[14:9] == 6'd0) return 16'h0000;
`endif
        return w;
    endfunction

    function automatic void chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_have_a = 0;
            m_cnt    = '0;
        end else begin
            bit    rdy, acc;
            pair_t p;
            rdy = !m_have_a || (q.size() < DEPTH);
            acc = in_valid && rdy;
            if (q.size() > 0 && op_ready) begin
                m_cnt = q[0].clr ? CNT_W'(1) : m_cnt + CNT_W'(1);
                void'(q.pop_front());
            end
            if (in_abort) begin
                m_have_a = 0;
            end else if (acc) begin
                if (!m_have_a) begin
                    m_a      = in_data;
                    m_clr    = in_clr;
                    m_have_a = 1;
                end else begin
                    p.clr = m_clr;
                    p.a   = ref_flush(m_a);
                    p.b   = ref_flush(in_data);
                    q.push_back(p);
                    m_have_a = 0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the reference
    always @(negedge clk) begin
        chk("in_ready", int'(in_ready), int'(!m_have_a || (q.size() < DEPTH)));
        chk("op_valid", int'(op_valid), int'(q.size() > 0));
        chk("fifo_level", int'(fifo_level), q.size());
        chk("pair_cnt", int'(pair_cnt), int'(m_cnt));
        chk("op_a", int'(op_a), q.size() > 0 ? int'(q[0].a) : 0);
        chk("op_b", int'(op_b), q.size() > 0 ? int'(q[0].b) : 0);
        chk("op_clr", int'(op_clr), q.size() > 0 ? int'(q[0].clr) : 0);
    end

    task automatic cyc(input bit v, input logic [15:0] d, input bit c, input bit ab, input bit r);
        in_valid = v;
        in_data  = d;
        in_clr   = c;
        in_abort = ab;
        op_ready = r;
        @(negedge clk);
    endtask

    task automatic drain();
        repeat (DEPTH + 2) cyc(0, 16'h0, 0, 0, 1);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_op_valid", int'(op_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic pair with clear tag
        cyc(1, 16'h3E00, 1, 0, 0);
        cyc(1, 16'h4000, 0, 0, 0);
        chk("pair1_valid", int'(op_valid), 1);
        chk("pair1_a", int'(op_a), 'h3E00);
        chk("pair1_b", int'(op_b), 'h4000);
        chk("pair1_clr", int'(op_clr), 1);
        cyc(0, 16'h0, 0, 0, 1);
        chk("pair1_cnt", int'(pair_cnt), 1);
        chk("pair1_level", int'(fifo_level), 0);

        // Fill to full, then stall the fifth B word
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1, 16'h4100 + 16'(i), 0, 0, 0);
            cyc(1, 16'h4200 + 16'(i), 0, 0, 0);
        end
        chk("full_level", int'(fifo_level), 4);
        cyc(1, 16'h4500, 0, 0, 0);
        chk("full_stall_ready", int'(in_ready), 0);
        cyc(1, 16'h4600, 0, 0, 1);
        chk("full_pop_level", int'(fifo_level), 3);
        chk("full_pop_ready", int'(in_ready), 1);
        cyc(1, 16'h4600, 0, 0, 0);
        chk("full_refill_level", int'(fifo_level), 4);
        drain();

        // Abort discards a held A word
        cyc(1, 16'h1234, 0, 0, 0);
        cyc(0, 16'h0, 0, 1, 0);
        cyc(1, 16'h0001, 0, 0, 0);
        cyc(1, 16'h0002, 0, 0, 0);
`ifdef DLFLOAT_ZERO_FLUSH_EN
        chk("abort_a", int'(op_a), 0);
`else
        chk("abort_a", int'(op_a), 1);
`endif
        drain();

        // Streaming at low occupancy with a clear in the middle
        cyc(1, 16'h5000, 0, 0, 0);
        cyc(1, 16'h5001, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 16'h5100 + 16'(i), (i == 10), 0, 1);
        end
        drain();

        // Asynchronous reset with two queued pairs and a pending A
        for (int i = 0; i < 5; i++) cyc(1, 16'h4800 + 16'(i), 0, 0, 0);
        chk("pre_rst_level", int'(fifo_level), 2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_op_valid", int'(op_valid), 0);
        chk("async_level", int'(fifo_level), 0);
        chk("async_cnt", int'(pair_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 16'h4100, 0, 0, 0);
        cyc(1, 16'h4200, 0, 0, 0);
        chk("post_rst_a", int'(op_a), 'h4100);
        drain();

        // Zero-exponent operand handling
        cyc(1, 16'h8005, 0, 0, 0);
        cyc(1, 16'h3E00, 0, 0, 0);
`ifdef DLFLOAT_ZERO_FLUSH_EN
        chk("flush_a", int'(op_a), 0);
`else
        chk("flush_a", int'(op_a), 'h8005);
`endif
        chk("flush_b", int'(op_b), 'h3E00);
        drain();

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom_range(0, 3) != 0), 16'($urandom),
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 2) != 0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
